// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
// Shares one AHB-Lite master port between NUM_CH requesting channels. A
// channel is granted from IDLE (or directly after a completed transfer),
// issues one NONSEQ address phase, then waits in the data phase for HREADY.
// A data-phase wait limit ends a hung transfer with an error completion.
//
// Parameters
//   NUM_CH          number of requesting channels (2..8)
//   DATA_WIDTH      AHB address and data width
//   ARB_MODE        0 = fixed priority (lowest index wins), 1 = round-robin
//   TIMEOUT_CYCLES  data-phase wait limit, 0 disables the timeout
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-low reset
//   ch_req_i/write/addr/wdata/size   per-channel request payload (flat buses)
//   ch_ready_o/rdata/err  per-channel completion pulse, read data, error
//   grant_o               one-hot bus owner, 0 while idle
//   haddr_o .. hwdata_o   AHB master request signals
//   hrdata_i, hready_i, hresp_i      AHB slave response
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate among requesters every cycle
// ADDR  | NONSEQ address phase of the granted channel, held until HREADY
// DATA  | data phase; completes on HREADY or on the wait-limit timeout
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_CH-1:0]            ch_req_i,
    input  logic [NUM_CH-1:0]            ch_write_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata_i,
    input  logic [NUM_CH*3-1:0]          ch_size_i,
    output logic [NUM_CH-1:0]            ch_ready_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata_o,
    output logic [NUM_CH-1:0]            ch_err_o,
    output logic [NUM_CH-1:0]            grant_o,
    output logic [DATA_WIDTH-1:0]        haddr_o,
    output logic                         hwrite_o,
    output logic [2:0]                   hsize_o,
    output logic [1:0]                   htrans_o,
    output logic [DATA_WIDTH-1:0]        hwdata_o,
    input  logic [DATA_WIDTH-1:0]        hrdata_i,
    input  logic                         hready_i,
    input  logic                         hresp_i
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                 state_q;
    logic [NUM_CH-1:0]      grant_q;
    logic [IDX_W-1:0]       grant_idx_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic [CNT_W-1:0]       wait_cnt_q;
    logic [DATA_WIDTH-1:0]  haddr_q;
    logic [DATA_WIDTH-1:0]  hwdata_q;
    logic                   hwrite_q;
    logic [2:0]             hsize_q;

    logic [NUM_CH-1:0]      arb_mask;
    logic                   arb_found;
    logic [IDX_W-1:0]       arb_idx;
    logic [IDX_W-1:0]       cand;
    logic                   xfer_done;
    logic                   xfer_timeout;
    logic                   take_grant;

    // Arbitration. After a completed transfer the channel just served is
    // masked out so another requester gets the bus back-to-back.
    always_comb begin
        arb_mask  = (state_q == S_DATA) ? (ch_req_i & ~grant_q) : ch_req_i;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ARB_MODE == 1) begin
                cand = IDX_W'((int'(last_grant_q) + 1 + i) % NUM_CH);
            end else begin
                cand = IDX_W'(i);
            end
            if (!arb_found && arb_mask[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        xfer_done    = (state_q == S_DATA) && hready_i;
        xfer_timeout = (TIMEOUT_CYCLES != 0) && (state_q == S_DATA) && !hready_i &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
        take_grant   = arb_found && ((state_q == S_IDLE) || xfer_done);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_CH - 1);
            wait_cnt_q   <= '0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'b000;
        end else begin
            // Payload is captured at grant time and held for the whole transfer.
            if (take_grant) begin
                grant_q      <= {{(NUM_CH-1){1'b0}}, 1'b1} << arb_idx;
                grant_idx_q  <= arb_idx;
                last_grant_q <= arb_idx;
                haddr_q      <= ch_addr_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                hwdata_q     <= ch_wdata_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                hwrite_q     <= ch_write_i[arb_idx];
                hsize_q      <= ch_size_i[int'(arb_idx)*3 +: 3];
            end
            case (state_q)
                S_IDLE: begin
                    if (arb_found) begin
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    wait_cnt_q <= '0;
                    if (hready_i) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer_done) begin
                        wait_cnt_q <= '0;
                        if (arb_found) begin
                            state_q <= S_ADDR;
                        end else begin
                            state_q <= S_IDLE;
                            grant_q <= '0;
                        end
                    end else if (xfer_timeout) begin
                        wait_cnt_q <= '0;
                        state_q    <= S_IDLE;
                        grant_q    <= '0;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Completion is combinational on the HREADY cycle; only the owner's slot
    // is ever driven, so non-granted channels stay 0.
    always_comb begin
        ch_ready_o = '0;
        ch_err_o   = '0;
        ch_rdata_o = '0;
        if (xfer_done) begin
            ch_ready_o[grant_idx_q] = 1'b1;
            ch_err_o[grant_idx_q]   = hresp_i;
            if (!hwrite_q) begin
                ch_rdata_o[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH] = hrdata_i;
            end
        end else if (xfer_timeout) begin
            ch_ready_o[grant_idx_q] = 1'b1;
            ch_err_o[grant_idx_q]   = 1'b1;
        end
    end

    assign grant_o  = grant_q;
    assign htrans_o = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign haddr_o  = (state_q != S_IDLE) ? haddr_q : '0;
    assign hwrite_o = (state_q != S_IDLE) ? hwrite_q : 1'b0;
    assign hsize_o  = (state_q != S_IDLE) ? hsize_q : 3'b000;
    assign hwdata_o = ((state_q == S_DATA) && hwrite_q) ? hwdata_q : '0;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_arbiter
// Two arbiters (fixed priority and round-robin, wait limit 4) share one set of
// stimulus. A transaction-level reference model per instance predicts every
// output every cycle; directed steps cover single read, back-to-back
// arbitration, error response, timeout and reset in the data phase, followed
// by randomized traffic.
// ---------------------------------------------------------------------------
module tb_ahb_master_arbiter;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int TO  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req, wr;
    logic [NCH*DW-1:0] addr, wdata;
    logic [NCH*3-1:0]  size;
    logic [DW-1:0]     hrdata;
    logic              hready, hresp;

    logic [NCH-1:0]    grant_w  [2];
    logic [NCH-1:0]    ready_w  [2];
    logic [NCH-1:0]    err_w    [2];
    logic [NCH*DW-1:0] rdata_w  [2];
    logic [DW-1:0]     haddr_w  [2];
    logic [DW-1:0]     hwdata_w [2];
    logic              hwrite_w [2];
    logic [2:0]        hsize_w  [2];
    logic [1:0]        htrans_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT_CYCLES(TO)) u_fp (
        .clk_i(clk), .reset_i(rst_n), .ch_req_i(req), .ch_write_i(wr), .ch_addr_i(addr),
        .ch_wdata_i(wdata), .ch_size_i(size), .ch_ready_o(ready_w[0]), .ch_rdata_o(rdata_w[0]),
        .ch_err_o(err_w[0]), .grant_o(grant_w[0]), .haddr_o(haddr_w[0]), .hwrite_o(hwrite_w[0]),
        .hsize_o(hsize_w[0]), .htrans_o(htrans_w[0]), .hwdata_o(hwdata_w[0]),
        .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp));

    ahb_master_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT_CYCLES(TO)) u_rr (
        .clk_i(clk), .reset_i(rst_n), .ch_req_i(req), .ch_write_i(wr), .ch_addr_i(addr),
        .ch_wdata_i(wdata), .ch_size_i(size), .ch_ready_o(ready_w[1]), .ch_rdata_o(rdata_w[1]),
        .ch_err_o(err_w[1]), .grant_o(grant_w[1]), .haddr_o(haddr_w[1]), .hwrite_o(hwrite_w[1]),
        .hsize_o(hsize_w[1]), .htrans_o(htrans_w[1]), .hwdata_o(hwdata_w[1]),
        .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp));

    // Reference model: owner is -1 when the bus is free; in_data is set once
    // the address phase has been accepted; waits counts stalled data cycles.
    typedef struct {
        int          owner;
        bit          in_data;
        int          waits;
        int          last;
        logic [DW-1:0] a;
        logic [DW-1:0] d;
        logic        w;
        logic [2:0]  sz;
    } mdl_t;

    mdl_t mdl [2];

    task automatic chk(input string tag, input logic [NCH*DW-1:0] obs, input logic [NCH*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int mode, input int last, input logic [NCH-1:0] r, input int excl);
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (mode == 1) ? (last + 1 + i) % NCH : i;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mdl[k].owner   = -1;
            mdl[k].in_data = 1'b0;
            mdl[k].waits   = 0;
            mdl[k].last    = NCH - 1;
            mdl[k].a       = '0;
            mdl[k].d       = '0;
            mdl[k].w       = 1'b0;
            mdl[k].sz      = 3'b000;
        end
    endtask

    task automatic model_grant(input int k, input int n);
        mdl[k].owner   = n;
        mdl[k].in_data = 1'b0;
        mdl[k].last    = n;
        mdl[k].a       = addr[n*DW +: DW];
        mdl[k].d       = wdata[n*DW +: DW];
        mdl[k].w       = wr[n];
        mdl[k].sz      = size[n*3 +: 3];
    endtask

    task automatic model_step(input int k);
        int o;
        int n;
        o = mdl[k].owner;
        if (o < 0) begin
            n = pick(k, mdl[k].last, req, -1);
            if (n >= 0) model_grant(k, n);
        end else if (!mdl[k].in_data) begin
            if (hready) begin
                mdl[k].in_data = 1'b1;
                mdl[k].waits   = 0;
            end
        end else if (hready) begin
            mdl[k].waits = 0;
            n = pick(k, mdl[k].last, req, o);
            if (n >= 0) model_grant(k, n);
            else mdl[k].owner = -1;
        end else if (mdl[k].waits == TO) begin
            mdl[k].owner = -1;
            mdl[k].waits = 0;
        end else begin
            mdl[k].waits++;
        end
    endtask

    task automatic check_inst(input int k);
        logic [NCH-1:0]    eg, er, ee;
        logic [NCH*DW-1:0] erd;
        logic [DW-1:0]     ea, ewd;
        logic              ew;
        logic [2:0]        es;
        logic [1:0]        et;
        int                o;
        eg = '0; er = '0; ee = '0; erd = '0; ea = '0; ewd = '0; ew = 1'b0; es = '0; et = '0;
        o = mdl[k].owner;
        if (o >= 0) begin
            eg[o] = 1'b1;
            ea    = mdl[k].a;
            ew    = mdl[k].w;
            es    = mdl[k].sz;
            if (!mdl[k].in_data) begin
                et = 2'b10;
            end else begin
                ewd = mdl[k].w ? mdl[k].d : '0;
                if (hready) begin
                    er[o] = 1'b1;
                    ee[o] = hresp;
                    if (!mdl[k].w) erd[o*DW +: DW] = hrdata;
                end else if (mdl[k].waits == TO) begin
                    er[o] = 1'b1;
                    ee[o] = 1'b1;
                end
            end
        end
        chk($sformatf("i%0d grant", k),  grant_w[k],  eg);
        chk($sformatf("i%0d ready", k),  ready_w[k],  er);
        chk($sformatf("i%0d err", k),    err_w[k],    ee);
        chk($sformatf("i%0d rdata", k),  rdata_w[k],  erd);
        chk($sformatf("i%0d haddr", k),  haddr_w[k],  ea);
        chk($sformatf("i%0d hwdata", k), hwdata_w[k], ewd);
        chk($sformatf("i%0d hwrite", k), hwrite_w[k], ew);
        chk($sformatf("i%0d hsize", k),  hsize_w[k],  es);
        chk($sformatf("i%0d htrans", k), htrans_w[k], et);
    endtask

    // Called just after a negedge with inputs already driven; returns at the
    // following negedge.
    task automatic cycle();
        #1;
        if (!rst_n) model_reset();
        check_inst(0);
        check_inst(1);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; wr = '0; addr = '0; wdata = '0; size = '0;
        hrdata = '0; hready = 1'b0; hresp = 1'b0;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Both channels requesting: both arbiters serve 0,1,0,1 back-to-back.
        addr[0*DW +: DW] = 32'h0000_0200;
        addr[1*DW +: DW] = 32'h0000_0300;
        size = 9'b000_010_010;
        req = 3'b011; hready = 1'b1; hrdata = 32'h1111_2222;
        cycle();
        for (int t = 0; t < 8; t++) begin
            logic [NCH-1:0] e;
            e = (((t / 2) % 2) == 1) ? 3'b010 : 3'b001;
            #1;
            chk("rr alternate", grant_w[1], e);
            chk("fp alternate", grant_w[0], e);
            cycle();
        end
        req = '0;
        repeat (3) cycle();

        // Single read of 0x100 by channel 0.
        addr[0*DW +: DW] = 32'h0000_0100;
        wr = '0; req = 3'b001; hrdata = 32'hDEAD_BEEF;
        cycle();
        req = '0;
        #1;
        chk("read nonseq", htrans_w[0], 2'b10);
        chk("read haddr", haddr_w[0], 32'h0000_0100);
        cycle();
        #1;
        chk("read ready", ready_w[0], 3'b001);
        chk("read rdata", rdata_w[0], 96'hDEAD_BEEF);
        cycle();

        // Two-cycle ERROR response on a write.
        wr = 3'b001; wdata[0*DW +: DW] = 32'hCAFE_0001; req = 3'b001;
        cycle();
        req = '0;
        cycle();
        hready = 1'b0; hresp = 1'b1;
        #1;
        chk("err first cycle", ready_w[0], 3'b000);
        cycle();
        hready = 1'b1;
        #1;
        chk("err ready", ready_w[0], 3'b001);
        chk("err flag", err_w[0], 3'b001);
        cycle();
        hresp = 1'b0;

        // Timeout with HREADY stuck low.
        wr = '0; req = 3'b001; hrdata = 32'h1234_5678;
        cycle();
        req = '0;
        cycle();
        hready = 1'b0;
        for (int t = 0; t < TO; t++) begin
            #1;
            chk("timeout early", ready_w[1], 3'b000);
            cycle();
        end
        #1;
        chk("timeout ready", ready_w[1], 3'b001);
        chk("timeout err", err_w[1], 3'b001);
        chk("timeout rdata", rdata_w[1], '0);
        cycle();
        hready = 1'b1;
        #1;
        chk("timeout idle", grant_w[1], 3'b000);
        cycle();

        // Reset while channel 1 is stalled in its data phase.
        req = 3'b010;
        cycle();
        cycle();
        hready = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst grant", grant_w[0] | grant_w[1], 3'b000);
        chk("rst haddr", haddr_w[0] | haddr_w[1], 32'h0);
        chk("rst htrans", htrans_w[0] | htrans_w[1], 2'b00);
        cycle();
        rst_n = 1'b1; hready = 1'b1;
        cycle();
        #1;
        chk("post-rst fp grant", grant_w[0], 3'b010);
        chk("post-rst rr grant", grant_w[1], 3'b010);
        cycle();

        // Randomized traffic with alternating fast/slow slave phases.
        for (int n = 0; n < 600; n++) begin
            int thr;
            thr = (((n / 100) % 2) == 1) ? 25 : 80;
            req = NCH'($urandom);
            for (int k = 0; k < NCH; k++) begin
                if (mdl[0].owner != k && mdl[1].owner != k) begin
                    addr[k*DW +: DW]  = $urandom;
                    wdata[k*DW +: DW] = $urandom;
                    wr[k]             = 1'($urandom_range(0, 1));
                    size[k*3 +: 3]    = 3'($urandom_range(0, 2));
                end
            end
            hready = ($urandom_range(0, 99) < thr);
            hresp  = ($urandom_range(0, 99) < 15);
            hrdata = $urandom;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of requesting channels (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: AHB data and address width.
REQ-003 The block SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16: data-phase wait limit; 0 disables the timeout.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning), with clock and reset first:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-low reset
- ch_req_i  in  NUM_CH  per-channel transfer request
- ch_write_i  in  NUM_CH  per-channel write enable
- ch_addr_i  in  NUM_CH*DATA_WIDTH  flat address bus; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- ch_wdata_i  in  NUM_CH*DATA_WIDTH  flat write data bus
- ch_size_i  in  NUM_CH*3  per-channel HSIZE
- ch_ready_o  out  NUM_CH  one-cycle completion pulse
- ch_rdata_o  out  NUM_CH*DATA_WIDTH  read data, valid with ready
- ch_err_o  out  NUM_CH  error flag, valid with ready
- grant_o  out  NUM_CH  one-hot owner of the bus; 0 in IDLE
- haddr_o  out  DATA_WIDTH  AHB address
- hwrite_o  out  1  AHB write
- hsize_o  out  3  AHB size
- htrans_o  out  2  AHB transfer type
- hwdata_o  out  DATA_WIDTH  AHB write data
- hrdata_i  in  DATA_WIDTH  AHB read data
- hready_i  in  1  AHB ready
- hresp_i  in  1  AHB response (1 = ERROR)

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-007 In IDLE, if any ch_req_i bit is set, the FSM SHALL register a grant chosen per ARB_MODE and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-008 In round-robin mode, the search SHALL start at last_grant+1 modulo NUM_CH; last_grant SHALL update at each new grant.
REQ-009 In ADDR, the block SHALL drive htrans_o=2'b10 (NONSEQ) and SHALL drive haddr_o, hwrite_o and hsize_o from the granted channel. It SHALL go to DATA when hready_i=1 and hold ADDR otherwise.
REQ-010 In DATA, the block SHALL drive htrans_o=2'b00 and hold haddr_o, hwrite_o and hsize_o. hwdata_o SHALL be the granted wdata when writing, else 0.
REQ-011 DATA SHALL complete on the first cycle with hready_i=1.
- ch_ready_o[g]=1 and ch_rdata_o[g]=hrdata_i (0 for writes), combinationally, in that same cycle.
- ch_err_o[g]=hresp_i.
REQ-012 A cycle with hresp_i=1 and hready_i=0 (first ERROR cycle) SHALL NOT complete the transfer.
REQ-013 On completion, the block SHALL re-arbitrate over the requesters excluding the just-served channel.
- If there is a winner: go directly to ADDR with the new grant.
- Otherwise: go to IDLE.
REQ-014 A wait counter SHALL count consecutive DATA cycles with hready_i=0.
- When it reaches TIMEOUT_CYCLES (if nonzero), the block SHALL pulse ch_ready_o[g]=1 and ch_err_o[g]=1 with rdata 0, and go to IDLE.
- The counter SHALL clear on leaving DATA.
REQ-015 The grant SHALL be locked from ADDR through completion; deassertion of ch_req_i mid-transfer SHALL be ignored.
REQ-016 Outputs of non-granted channels SHALL always be 0.
- At most one ch_ready_o bit SHALL be set in any cycle.
- grant_o SHALL be one-hot in ADDR and DATA.
REQ-017 In IDLE, haddr_o, hwdata_o, hwrite_o, hsize_o and htrans_o SHALL all be 0.

Reset
REQ-018 Asserting reset_i low at any time, including mid-transfer, SHALL asynchronously force:
- state to IDLE
- wait counter to 0
- last_grant to NUM_CH-1
- all outputs to 0
REQ-019 After reset is released, the first grant SHALL be channel 0 in both modes, when channel 0 requests.

Verification
REQ-020 The bench SHALL cover a single read: ch0 reads 0x100, slave returns 0xDEADBEEF with hready=1.
- Required: htrans NONSEQ in cycle 1.
- Required: ch_ready_o[0] with rdata 0xDEADBEEF in cycle 2.
REQ-021 The bench SHALL cover simultaneous requests with ARB_MODE=1: ch0 and ch1 requesting continuously.
- Required: grants alternate 0,1,0,1.
- Required: no IDLE cycle between back-to-back transfers.
REQ-022 The bench SHALL cover simultaneous requests with ARB_MODE=0: ch0 and ch1 both request.
- Required: ch0 is served first.
- Required: ch1 is served next (served channel excluded), without an IDLE cycle.
REQ-023 The bench SHALL cover an error response: slave drives hresp=1/hready=0, then hresp=1/hready=1.
- Required: no ready pulse in the first cycle.
- Required: ch_ready_o and ch_err_o=1 in the second cycle.
REQ-024 The bench SHALL cover a timeout: TIMEOUT_CYCLES=4 and hready held low.
- Required: after 4 DATA cycles, ch_ready_o=1, ch_err_o=1 and rdata 0, then IDLE.
REQ-025 The bench SHALL cover reset during DATA: reset_i pulses low.
- Required: all outputs 0 immediately.
- Required: on release with ch1 requesting, ch1 is granted from IDLE.
